// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder_if
// Description : Byte-serial RAM bus between the memory controller (master)
//               and the RAM/I-O responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_responder_if;
  logic        ram_rw_sel;   // 0 = read, 1 = write
  logic [31:0] ram_addr;     // byte address
  logic [7:0]  ram_wr_byte;  // write data
  logic [7:0]  ram_rd_byte;  // read data, one cycle after the address edge
  logic        io_full;      // TX queue nearly full, controller must stall

  modport master (
    output ram_rw_sel, ram_addr, ram_wr_byte,
    input  ram_rd_byte, io_full
  );

  modport slave (
    input  ram_rw_sel, ram_addr, ram_wr_byte,
    output ram_rd_byte, io_full
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Responder end of the byte-serial RAM bus. Byte-addressable
//               main memory plus an I/O window holding a TX byte queue,
//               an RX byte port and a sticky sim-end flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder #(
  parameter int          MEM_AW    = 17,
  parameter logic [31:0] IO_BASE   = 32'h30000,
  parameter int          TXQ_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,          // asynchronous, active-low
  input  logic                  rdy,
  ram_responder_if.slave        bus,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ack,
  output logic                  tx_overflow,
  output logic                  sim_end
);

  localparam int                  c_ptr_w    = $clog2(TXQ_DEPTH);
  localparam int                  c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(TXQ_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_full_thr = c_cnt_w'(TXQ_DEPTH - 1);
  localparam logic [31:0]         c_io_end   = IO_BASE + 32'd4;

  // Storage (never reset)
  logic [7:0]          r_mem [0:(2**MEM_AW)-1];
  logic [7:0]          r_txq [0:TXQ_DEPTH-1];

  // Registered state
  logic [7:0]          r_rd_byte;
  logic                r_io_full;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;
  logic                r_rx_ack;
  logic                r_tx_overflow;
  logic                r_sim_end;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  // Decode and queue next-state
  logic                w_is_mem;
  logic                w_is_port;
  logic                w_is_end;
  logic                w_wr;
  logic                w_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;
  logic [c_ptr_w-1:0]  w_wr_ptr_nxt;
  logic [c_ptr_w-1:0]  w_rd_ptr_nxt;
  logic [c_cnt_w-1:0]  w_count_nxt;
  logic [7:0]          w_head_nxt;

  // Address decode, push/pop qualification and next head byte
  always_comb begin
    w_is_mem     = bus.ram_addr < IO_BASE;
    w_is_port    = bus.ram_addr == IO_BASE;
    w_is_end     = bus.ram_addr == c_io_end;
    w_wr         = rdy && bus.ram_rw_sel;
    w_rd         = rdy && !bus.ram_rw_sel;
    w_push       = w_wr && w_is_port;
    w_pop        = r_tx_valid && tx_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    w_push_ok    = w_push && ((r_count != c_depth) || w_pop);
    w_drop       = w_push && !w_push_ok;
    w_wr_ptr_nxt = r_wr_ptr + c_ptr_w'(w_push_ok);
    w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_pop);
    w_count_nxt  = r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);
    w_head_nxt   = 8'h00;
    if (w_count_nxt != '0) begin
      // The new head is the byte being pushed when it lands in the head slot
      if (w_push_ok && (w_rd_ptr_nxt == r_wr_ptr))
        w_head_nxt = bus.ram_wr_byte;
      else
        w_head_nxt = r_txq[w_rd_ptr_nxt];
    end
  end

  // Memory and queue storage writes; suppressed while reset is held
  always_ff @(posedge clk) begin
    if (rst && w_wr && w_is_mem)
      r_mem[bus.ram_addr[MEM_AW-1:0]] <= bus.ram_wr_byte;
    if (rst && w_push_ok)
      r_txq[r_wr_ptr] <= bus.ram_wr_byte;
  end

  // Bus read data, RX acknowledge and sim-end flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_byte <= 8'h00;
      r_rx_ack  <= 1'b0;
      r_sim_end <= 1'b0;
    end else begin
      r_rx_ack <= w_rd && w_is_port && rx_valid;
      if (w_wr && w_is_end)
        r_sim_end <= 1'b1;
      if (rdy) begin
        if (bus.ram_rw_sel)
          r_rd_byte <= 8'h00;
        else if (w_is_mem)
          r_rd_byte <= r_mem[bus.ram_addr[MEM_AW-1:0]];
        else if (w_is_port)
          r_rd_byte <= rx_valid ? rx_data : 8'h00;
        else
          r_rd_byte <= 8'h00;
      end
    end
  end

  // TX queue pointers, count and registered queue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_io_full     <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      // One slot held back: the controller sees io_full a cycle late
      r_io_full  <= w_count_nxt >= c_full_thr;
      r_tx_valid <= w_count_nxt != '0;
      r_tx_data  <= w_head_nxt;
      if (w_drop)
        r_tx_overflow <= 1'b1;
    end
  end

  assign bus.ram_rd_byte = r_rd_byte;
  assign bus.io_full     = r_io_full;
  assign tx_valid        = r_tx_valid;
  assign tx_data         = r_tx_data;
  assign rx_ack          = r_rx_ack;
  assign tx_overflow     = r_tx_overflow;
  assign sim_end         = r_sim_end;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Directed self-checking bench for ram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

  localparam logic [31:0] c_io_base = 32'h30000;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       tx_overflow;
  logic       sim_end;

  int n_cmp;
  int n_err;

  ram_responder_if bus ();

  ram_responder #(
    .MEM_AW    (17),
    .IO_BASE   (c_io_base),
    .TXQ_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ack      (rx_ack),
    .tx_overflow (tx_overflow),
    .sim_end     (sim_end)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
    bus.ram_rw_sel  = 1'b1;
    bus.ram_addr    = addr;
    bus.ram_wr_byte = data;
    step();
  endtask

  task automatic bus_rd(input logic [31:0] addr);
    bus.ram_rw_sel  = 1'b0;
    bus.ram_addr    = addr;
    bus.ram_wr_byte = 8'h00;
    step();
  endtask

  // Idle bus: read an unmapped I/O address, which has no side effects
  task automatic bus_idle();
    bus_rd(c_io_base + 32'd8);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    rdy = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bus.ram_rw_sel  = 1'b0;
    bus.ram_addr    = c_io_base + 32'd8;
    bus.ram_wr_byte = 8'h00;
    #1 rst = 1'b0;
    #2;
    // Reset state
    chk("rst_rd_byte",  {24'd0, bus.ram_rd_byte}, 32'h0);
    chk("rst_io_full",  {31'd0, bus.io_full},     32'h0);
    chk("rst_tx_valid", {31'd0, tx_valid},        32'h0);
    chk("rst_tx_data",  {24'd0, tx_data},         32'h0);
    chk("rst_rx_ack",   {31'd0, rx_ack},          32'h0);
    chk("rst_overflow", {31'd0, tx_overflow},     32'h0);
    chk("rst_sim_end",  {31'd0, sim_end},         32'h0);
    step();
    rst = 1'b1;

    // Memory write then read with one-cycle latency, aliasing, unmapped I/O
    bus_wr(32'h100, 8'hA5);
    chk("t1_rd_after_wr", {24'd0, bus.ram_rd_byte}, 32'h0);
    bus_wr(32'h300, 8'h5A);
    bus_wr(32'h200, 8'h11);
    bus_rd(32'h100);
    chk("t1_rd_a5", {24'd0, bus.ram_rd_byte}, 32'hA5);
    bus_rd(c_io_base + 32'd8);
    chk("t1_io_other_rd", {24'd0, bus.ram_rd_byte}, 32'h0);
    bus_rd(32'h20100);
    chk("t1_alias_rd", {24'd0, bus.ram_rd_byte}, 32'hA5);
    bus_wr(c_io_base + 32'd8, 8'hFF);
    chk("t1_io_other_wr_rd", {24'd0, bus.ram_rd_byte}, 32'h0);
    chk("t1_io_other_wr_end", {31'd0, sim_end}, 32'h0);
    chk("t1_io_other_wr_txv", {31'd0, tx_valid}, 32'h0);

    // Fill the TX queue with no consumer
    for (int k = 1; k <= 8; k++) begin
      bus_wr(c_io_base, 8'(k));
      chk($sformatf("t2_io_full_%0d", k), {31'd0, bus.io_full}, (k >= 7) ? 32'h1 : 32'h0);
    end
    chk("t2_tx_valid", {31'd0, tx_valid},    32'h1);
    chk("t2_tx_head",  {24'd0, tx_data},     32'h1);
    chk("t2_no_ovf",   {31'd0, tx_overflow}, 32'h0);
    bus_wr(c_io_base, 8'd9);
    chk("t2_ovf",      {31'd0, tx_overflow}, 32'h1);
    chk("t2_head_kept", {24'd0, tx_data},    32'h1);
    chk("t2_full_kept", {31'd0, bus.io_full}, 32'h1);

    // Push and pop together while full, then drain across the pointer wrap
    tx_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      bus_wr(c_io_base, 8'(9 + j));
      chk($sformatf("t3_pp_head_%0d", j), {24'd0, tx_data}, (j < 8) ? 32'(j + 1) : 32'd10);
      chk($sformatf("t3_pp_full_%0d", j), {31'd0, bus.io_full}, 32'h1);
    end
    for (int k = 1; k <= 8; k++) begin
      bus_idle();
      chk($sformatf("t3_dr_valid_%0d", k), {31'd0, tx_valid}, (k < 8) ? 32'h1 : 32'h0);
      if (k < 8)
        chk($sformatf("t3_dr_head_%0d", k), {24'd0, tx_data}, 32'(10 + k));
      chk($sformatf("t3_dr_full_%0d", k), {31'd0, bus.io_full}, (k <= 1) ? 32'h1 : 32'h0);
    end
    tx_ready = 1'b0;
    chk("t3_ovf_sticky", {31'd0, tx_overflow}, 32'h1);

    // RX port reads
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    bus_rd(c_io_base);
    chk("t4_rx_rd",  {24'd0, bus.ram_rd_byte}, 32'h3C);
    chk("t4_rx_ack", {31'd0, rx_ack},          32'h1);
    bus_idle();
    chk("t4_ack_single", {31'd0, rx_ack},          32'h0);
    chk("t4_idle_rd",    {24'd0, bus.ram_rd_byte}, 32'h0);
    rx_valid = 1'b0;
    bus_rd(c_io_base);
    chk("t4_norx_rd",  {24'd0, bus.ram_rd_byte}, 32'h0);
    chk("t4_norx_ack", {31'd0, rx_ack},          32'h0);

    // Bus frozen by rdy=0, TX drain still active
    bus_wr(c_io_base, 8'h55);
    chk("t5_txv", {31'd0, tx_valid}, 32'h1);
    chk("t5_txd", {24'd0, tx_data},  32'h55);
    bus_rd(32'h200);
    chk("t5_rd_200", {24'd0, bus.ram_rd_byte}, 32'h11);
    rdy = 1'b0;
    bus_wr(32'h200, 8'h99);
    chk("t5_rd_hold", {24'd0, bus.ram_rd_byte}, 32'h11);
    bus_wr(c_io_base, 8'h77);
    chk("t5_q_txd", {24'd0, tx_data},  32'h55);
    chk("t5_q_txv", {31'd0, tx_valid}, 32'h1);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    bus_rd(c_io_base);
    chk("t5_no_ack",  {31'd0, rx_ack},          32'h0);
    chk("t5_rd_hold2", {24'd0, bus.ram_rd_byte}, 32'h11);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    bus_idle();
    chk("t5_drain", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rdy = 1'b1;
    bus_rd(32'h200);
    chk("t5_mem_kept", {24'd0, bus.ram_rd_byte}, 32'h11);

    // Asynchronous reset mid-burst
    bus_wr(c_io_base + 32'd4, 8'h00);
    chk("t6_sim_end", {31'd0, sim_end}, 32'h1);
    bus_wr(c_io_base, 8'hA1);
    bus_wr(c_io_base, 8'hA2);
    bus_wr(c_io_base, 8'hA3);
    chk("t6_txv",  {31'd0, tx_valid},    32'h1);
    chk("t6_full", {31'd0, bus.io_full}, 32'h0);
    bus_rd(32'h100);
    chk("t6_rd_pre", {24'd0, bus.ram_rd_byte}, 32'hA5);
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    bus_rd(c_io_base);
    chk("t6_ack_pre", {31'd0, rx_ack}, 32'h1);
    bus.ram_rw_sel  = 1'b1;
    bus.ram_addr    = 32'h300;
    bus.ram_wr_byte = 8'h42;
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_rd",   {24'd0, bus.ram_rd_byte}, 32'h0);
    chk("t6_rst_full", {31'd0, bus.io_full},     32'h0);
    chk("t6_rst_txv",  {31'd0, tx_valid},        32'h0);
    chk("t6_rst_txd",  {24'd0, tx_data},         32'h0);
    chk("t6_rst_ack",  {31'd0, rx_ack},          32'h0);
    chk("t6_rst_ovf",  {31'd0, tx_overflow},     32'h0);
    chk("t6_rst_end",  {31'd0, sim_end},         32'h0);
    step();
    rst = 1'b1;
    rx_valid = 1'b0;
    bus_idle();
    chk("t6_post_txv", {31'd0, tx_valid}, 32'h0);
    chk("t6_post_end", {31'd0, sim_end},  32'h0);
    bus_rd(32'h300);
    chk("t6_mem_300", {24'd0, bus.ram_rd_byte}, 32'h5A);
    bus_rd(32'h100);
    chk("t6_mem_100", {24'd0, bus.ram_rd_byte}, 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
